dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port data_memory (4 KB, word-aligned, synchronous write, combinational read).
- Port 0 is the core load/store unit; port 1 is a secondary master (debug/DMA loader).
- Accepts one request at a time with round-robin fairness and drives MemRead/MemWrite for exactly one access cycle.
- Returns a registered read-data/write-ack pulse to the owning port, and rejects misaligned or out-of-range addresses with an error response instead of touching memory.

Parameters:
- ADDR_W, 32, request/memory address width.
- DATA_W, 32, data width.
- MEM_BYTES, 4096, decoded memory size in bytes; addresses >= MEM_BYTES are errors.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- m0_req  in  1  port 0 request valid; held with fields stable until m0_gnt
- m0_we  in  1  port 0 write (1) / read (0)
- m0_addr  in  ADDR_W  port 0 byte address
- m0_wdata  in  DATA_W  port 0 write data
- m0_gnt  out  1  port 0 request accepted this cycle (combinational)
- m0_rvalid  out  1  port 0 response pulse, one cycle
- m0_rdata  out  DATA_W  port 0 read data, valid with m0_rvalid
- m0_err  out  1  port 0 error flag, valid with m0_rvalid
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as port 0, for port 1
- MemRead  out  1  to data_memory
- MemWrite  out  1  to data_memory
- mem_addr  out  ADDR_W  to data_memory addr
- mem_write_data  out  DATA_W  to data_memory write_data
- mem_read_data  in  DATA_W  from data_memory read_data

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; last_owner=1, so port 0 wins the first tie.
  - All latched request registers cleared.
  - MemRead=MemWrite=0, mem_addr=mem_write_data=0.
  - All rvalid/err=0, rdata=0.
  - Reset mid-ACCESS abandons the access: MemWrite drops immediately and no response is issued.
- FSM states: IDLE, ACCESS.
- IDLE:
  - If exactly one req is high, that port wins.
  - If both are high, the port != last_owner wins.
  - The winner's mX_gnt=1 this cycle (the loser's gnt=0).
  - At the clock edge, latch we/addr/wdata/owner, update last_owner, go to ACCESS.
  - No req: stay in IDLE, gnt=0.
- Error check at latch:
  - err_lat = (addr[1:0]!=0) or (addr >= MEM_BYTES).
- ACCESS (exactly 1 cycle, then IDLE):
  - No error: mem_addr=latched addr; MemWrite=we; MemRead=!we; mem_write_data=latched wdata.
  - Error: MemRead=MemWrite=0.
  - At the clock edge, owner's rvalid register <= 1; rdata <= (read and no error) ? mem_read_data : 0; err <= err_lat.
- Response timing:
  - rvalid is high for exactly one cycle: the cycle after ACCESS, which is an IDLE cycle that may accept a new request.
  - Writes also produce rvalid as an acknowledge, with rdata=0.
- Outside ACCESS: MemRead=MemWrite=0; mem_addr and mem_write_data are driven to 0.
- Latency and throughput:
  - Request accepted in cycle T (gnt), memory accessed in T+1, response in T+2.
  - Maximum throughput is one access per 2 cycles.
- Fairness: with both ports continuously requesting, grants strictly alternate 0,1,0,1…
- gnt is never asserted outside IDLE.
- Request fields are sampled only in the gnt cycle; changes afterward have no effect.
- A port may raise a new req while awaiting its rvalid; it is arbitrated normally in the next IDLE cycle.
- Only one of m0_rvalid/m1_rvalid is high in any cycle.
- Width rule: the MEM_BYTES compare uses the full ADDR_W address; no truncation before the check.

Test Plan:
- Reset, then m0 write addr=0x10 wdata=0xDEADBEEF -> m0_gnt at T, MemWrite=1 with mem_addr=0x10 at T+1, m0_rvalid=1, err=0, rdata=0 at T+2; then m0 read 0x10 -> MemRead at access cycle, m0_rdata=0xDEADBEEF with rvalid.
- Both ports request reads continuously from reset (m0 addr 0x0, m1 addr 0x4) -> grants in order m0,m1,m0,m1; rvalids alternate; no cycle has both gnt or both rvalid.
- m1 read addr=0x6 (misaligned) -> MemRead=MemWrite=0 throughout, m1_rvalid=1 with m1_err=1, m1_rdata=0; m1 write addr=0x1000 -> err=1, memory contents unchanged (confirm by reading 0xFFC).
- Single port back-to-back: m0_req held high for 3 reads -> gnt at T, T+2, T+4; responses at T+2, T+4, T+6.
- Assert rst_n=0 during the ACCESS cycle of an m0 write to 0x20 -> MemWrite drops asynchronously, no m0_rvalid; after release, read 0x20 returns the pre-reset value, and first tie goes to port 0.
- Change m1_addr/m1_wdata in the cycle after m1_gnt -> the memory access uses the values from the gnt cycle.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and sequencer for the
// single-port data_memory (synchronous write, combinational read).
//
// One request is accepted at a time. A granted request is latched, then
// drives exactly one memory access cycle. A one-cycle registered response
// (rvalid/rdata/err) goes back to the owning port on the following cycle.
// Misaligned or out-of-range addresses never touch memory. Instead, they
// return err=1 with rdata=0.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   mX_req/we/addr/wdata          port X request; fields held until mX_gnt
//   mX_gnt                        port X accepted this cycle (combinational)
//   mX_rvalid/rdata/err           port X one-cycle response
//   MemRead/MemWrite              memory strobes, high only in the access cycle
//   mem_addr/mem_write_data       memory address/data, zero outside an access
//   mem_read_data                 memory combinational read data
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    typedef enum logic {IDLE, ACCESS} state_t;

    typedef struct packed {
        logic              owner;
        logic              we;
        logic              err;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    // The range check uses the full address width, so high address bits
    // cannot alias into the decoded window.
    localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);

    state_t            state, state_nxt;
    logic              last_owner;
    req_t              lat;
    logic [1:0]        req, gnt;
    logic              win, take;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              acc_ok;

    logic [1:0]             rvalid_q, err_q;
    logic [1:0][DATA_W-1:0] rdata_q;

    assign req = {m1_req, m0_req};

    // Arbitration happens only in IDLE. On a tie, the port that did not
    // own the previous access wins.
    always_comb begin
        win       = 1'b0;
        take      = 1'b0;
        gnt       = 2'b00;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (|req) begin
                    win       = (&req) ? ~last_owner : req[1];
                    take      = 1'b1;
                    gnt       = win ? 2'b10 : 2'b01;
                    state_nxt = ACCESS;
                end
            end
            ACCESS:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];

    assign sel_we    = win ? m1_we    : m0_we;
    assign sel_addr  = win ? m1_addr  : m0_addr;
    assign sel_wdata = win ? m1_wdata : m0_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            lat        <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                lat.owner  <= win;
                lat.we     <= sel_we;
                lat.addr   <= sel_addr;
                lat.wdata  <= sel_wdata;
                lat.err    <= (sel_addr[1:0] != 2'b00) || (sel_addr >= MEM_LIMIT);
                last_owner <= win;
            end
        end
    end

    // Memory strobes come combinationally from the state register. An
    // asynchronous reset therefore drops MemWrite immediately.
    assign acc_ok         = (state == ACCESS) && !lat.err;
    assign MemRead        = acc_ok && !lat.we;
    assign MemWrite       = acc_ok && lat.we;
    assign mem_addr       = acc_ok ? lat.addr  : '0;
    assign mem_write_data = acc_ok ? lat.wdata : '0;

    // rdata/err hold between pulses. They are meaningful only with rvalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if ((state == ACCESS) && (lat.owner == 1'(p))) begin
                    rvalid_q[p] <= 1'b1;
                    err_q[p]    <= lat.err;
                    rdata_q[p]  <= (!lat.we && !lat.err) ? mem_read_data : '0;
                end else begin
                    rvalid_q[p] <= 1'b0;
                end
            end
        end
    end

    assign m0_rvalid = rvalid_q[0];
    assign m0_err    = err_q[0];
    assign m0_rdata  = rdata_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m1_err    = err_q[1];
    assign m1_rdata  = rdata_q[1];

endmodule
